// File: rtl/sim_halt_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_halt_monitor_if
//  Description : Commit-stage bundle observed by the halt monitor. It carries
//                the per-channel commit strobes, instructions and PCs, the a0
//                architectural value and the external abort request.
//                master : driven by the core / sim top (outputs)
//                slave  : seen by the monitor (inputs)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_halt_monitor_if #(
    parameter int NCHAN = 1,
    parameter int XLEN  = 64
);
    logic [NCHAN-1:0]      commit_valid;
    logic [32*NCHAN-1:0]   commit_inst;
    logic [XLEN*NCHAN-1:0] commit_pc;
    logic [XLEN-1:0]       a0;
    logic                  halt_req;

    modport master (
        output commit_valid,
        output commit_inst,
        output commit_pc,
        output a0,
        output halt_req
    );

    modport slave (
        input commit_valid,
        input commit_inst,
        input commit_pc,
        input a0,
        input halt_req
    );
endinterface
`default_nettype wire

// File: rtl/sim_halt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sim_halt_monitor
//  Description : Halt/trap monitor on the NPC commit stage. It detects ebreak
//                (32'h00100073), external abort requests and a no-commit
//                watchdog. It then drains for a fixed number of cycles and
//                holds the halt cause, code and PC until reset. It also keeps
//                retired-instruction and cycle counters.
//  Ports       : clock, reset       - clock, synchronous active-high reset
//                commit_if (slave)  - commit_valid/inst/pc, a0, halt_req
//                halted             - high while halted (sticky)
//                halt_valid         - pulse on first halted cycle
//                halt_cause/code/pc - latched halt information
//                retired_cnt        - committed instruction count
//                cycle_cnt          - cycles spent in RUN and DRAIN
//  Options     : SIM_HALT_DPI_EN - when defined, on the first halted cycle the
//                block reports the halt code and then calls $finish. It first
//                reports the cause and PC when the cause is TIMEOUT or ABORT.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_halt_monitor #(
    parameter int NCHAN          = 1,
    parameter int XLEN           = 64,
    parameter int DRAIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  wire logic             clock,
    input  wire logic             reset,
    sim_halt_monitor_if.slave     commit_if,
    output logic                  halted,
    output logic                  halt_valid,
    output logic [2:0]            halt_cause,
    output logic [31:0]           halt_code,
    output logic [XLEN-1:0]       halt_pc,
    output logic [63:0]           retired_cnt,
    output logic [63:0]           cycle_cnt
);

    localparam logic [31:0] c_EBREAK        = 32'h0010_0073;
    localparam logic [2:0]  c_CAUSE_NONE    = 3'd0;
    localparam logic [2:0]  c_CAUSE_GOOD    = 3'd1;
    localparam logic [2:0]  c_CAUSE_BAD     = 3'd2;
    localparam logic [2:0]  c_CAUSE_TIMEOUT = 3'd3;
    localparam logic [2:0]  c_CAUSE_ABORT   = 3'd4;
    localparam logic [31:0] c_CODE_TIMEOUT  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CODE_ABORT    = 32'hDEAD_0001;
    localparam bit          c_WD_EN         = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] c_TIMEOUT       = 32'(TIMEOUT_CYCLES);
    // DRAIN always lasts at least one cycle, so a zero setting behaves as one.
    localparam logic [31:0] c_DRAIN_LAST    = (DRAIN_CYCLES == 0) ? 32'd0
                                                                  : 32'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_halted;
    logic              r_halt_valid;
    logic              w_halted_next;
    logic              w_halt_valid_next;

    logic [2:0]        r_cause;
    logic [31:0]       r_code;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_last_pc;
    logic [63:0]       r_retired;
    logic [63:0]       r_cycles;
    logic [31:0]       r_idle_cnt;
    logic [31:0]       r_drain_cnt;

    logic              w_ebreak_found;
    logic [XLEN-1:0]   w_ebreak_pc;
    logic [XLEN-1:0]   w_last_pc;
    logic [3:0]        w_retire_inc;
    logic              w_any_commit;
    logic              w_timeout;
    logic              w_event;

    // Walk the channels oldest-first. Retirement and the last-PC tracker stop
    // at the first ebreak, so younger channels of that group never retire.
    always_comb begin
        w_ebreak_found = 1'b0;
        w_ebreak_pc    = '0;
        w_last_pc      = r_last_pc;
        w_retire_inc   = 4'd0;
        for (int i = 0; i < NCHAN; i++) begin
            if (commit_if.commit_valid[i] && !w_ebreak_found) begin
                w_retire_inc = w_retire_inc + 4'd1;
                w_last_pc    = commit_if.commit_pc[XLEN*i +: XLEN];
                if (commit_if.commit_inst[32*i +: 32] == c_EBREAK) begin
                    w_ebreak_found = 1'b1;
                    w_ebreak_pc    = commit_if.commit_pc[XLEN*i +: XLEN];
                end
            end
        end
    end

    assign w_any_commit = |commit_if.commit_valid;
    // The idle counter holds the previous idle streak, so this cycle is the
    // Nth idle cycle when the counter plus one reaches the limit.
    assign w_timeout    = c_WD_EN && !w_any_commit && ((r_idle_cnt + 32'd1) == c_TIMEOUT);
    assign w_event      = w_ebreak_found || commit_if.halt_req || w_timeout;

    // FSM: next state and registered status flags
    always_comb begin
        w_state_next      = r_state;
        w_halted_next     = r_halted;
        w_halt_valid_next = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_event) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_next      = ST_HALTED;
                    w_halted_next     = 1'b1;
                    w_halt_valid_next = 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_halted     <= 1'b0;
            r_halt_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_halted     <= w_halted_next;
            r_halt_valid <= w_halt_valid_next;
        end
    end

    // Datapath: counters and latched halt information
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cause     <= c_CAUSE_NONE;
            r_code      <= '0;
            r_pc        <= '0;
            r_last_pc   <= '0;
            r_retired   <= '0;
            r_cycles    <= '0;
            r_idle_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycles    <= r_cycles + 64'd1;
                    r_retired   <= r_retired + 64'(w_retire_inc);
                    r_last_pc   <= w_last_pc;
                    r_idle_cnt  <= w_any_commit ? 32'd0 : (r_idle_cnt + 32'd1);
                    r_drain_cnt <= '0;
                    if (w_ebreak_found) begin
                        r_cause <= (commit_if.a0 == '0) ? c_CAUSE_GOOD : c_CAUSE_BAD;
                        r_code  <= commit_if.a0[31:0];
                        r_pc    <= w_ebreak_pc;
                    end else if (commit_if.halt_req) begin
                        r_cause <= c_CAUSE_ABORT;
                        r_code  <= c_CODE_ABORT;
                        r_pc    <= w_last_pc;
                    end else if (w_timeout) begin
                        r_cause <= c_CAUSE_TIMEOUT;
                        r_code  <= c_CODE_TIMEOUT;
                        r_pc    <= r_last_pc;
                    end
                end
                ST_DRAIN: begin
                    r_cycles    <= r_cycles + 64'd1;
                    r_drain_cnt <= r_drain_cnt + 32'd1;
                end
                default: begin
                    // HALTED: everything frozen until reset
                end
            endcase
        end
    end

    assign halted      = r_halted;
    assign halt_valid  = r_halt_valid;
    assign halt_cause  = r_cause;
    assign halt_code   = r_code;
    assign halt_pc     = r_pc;
    assign retired_cnt = r_retired;
    assign cycle_cnt   = r_cycles;

`ifdef SIM_HALT_DPI_EN
    always_ff @(posedge clock) begin
        if (!reset && r_halt_valid) begin
            if (r_cause == c_CAUSE_TIMEOUT || r_cause == c_CAUSE_ABORT) begin
                $display("sim_halt_monitor: cause %0d at pc 0x%0h", r_cause, r_pc);
            end
            $display("sim_halt_monitor: halt code 0x%0h", r_code);
            $finish;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_halt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_halt_monitor
//  Description : Directed self-checking bench for sim_halt_monitor. Instance
//                A uses NCHAN=2, DRAIN_CYCLES=2 and TIMEOUT_CYCLES=8. Instance
//                B uses NCHAN=1, DRAIN_CYCLES=0 and has the watchdog off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_halt_monitor;

    localparam logic [31:0] c_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_ADDI   = 32'h0000_0013;

    logic clock;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_errors = 0;

    sim_halt_monitor_if #(.NCHAN(2), .XLEN(64)) bus_a ();
    sim_halt_monitor_if #(.NCHAN(1), .XLEN(64)) bus_b ();

    logic        halted_a, halt_valid_a, halted_b, halt_valid_b;
    logic [2:0]  cause_a, cause_b;
    logic [31:0] code_a, code_b;
    logic [63:0] pc_a, pc_b, ret_a, ret_b, cyc_a, cyc_b;

    sim_halt_monitor #(
        .NCHAN(2), .XLEN(64), .DRAIN_CYCLES(2), .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clock       (clock),
        .reset       (rst_a),
        .commit_if   (bus_a.slave),
        .halted      (halted_a),
        .halt_valid  (halt_valid_a),
        .halt_cause  (cause_a),
        .halt_code   (code_a),
        .halt_pc     (pc_a),
        .retired_cnt (ret_a),
        .cycle_cnt   (cyc_a)
    );

    sim_halt_monitor #(
        .NCHAN(1), .XLEN(64), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)
    ) u_dut_b (
        .clock       (clock),
        .reset       (rst_b),
        .commit_if   (bus_b.slave),
        .halted      (halted_b),
        .halt_valid  (halt_valid_b),
        .halt_cause  (cause_b),
        .halt_code   (code_b),
        .halt_pc     (pc_b),
        .retired_cnt (ret_b),
        .cycle_cnt   (cyc_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance A, then wait for the next falling edge.
    task automatic step_a(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [63:0] p0, input logic [63:0] p1,
                          input logic [63:0] a, input logic req);
        bus_a.commit_valid = v;
        bus_a.commit_inst  = {i1, i0};
        bus_a.commit_pc    = {p1, p0};
        bus_a.a0           = a;
        bus_a.halt_req     = req;
        @(negedge clock);
    endtask

    task automatic idle_a();
        step_a(2'b00, c_ADDI, c_ADDI, 64'h0, 64'h0, 64'h0, 1'b0);
    endtask

    task automatic step_b(input logic v, input logic [31:0] i0, input logic [63:0] p0,
                          input logic [63:0] a, input logic req);
        bus_b.commit_valid = v;
        bus_b.commit_inst  = i0;
        bus_b.commit_pc    = p0;
        bus_b.a0           = a;
        bus_b.halt_req     = req;
        @(negedge clock);
    endtask

    task automatic reset_pulse_a();
        rst_a = 1'b1;
        idle_a();
        rst_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        step_b(1'b0, c_ADDI, 64'h0, 64'h0, 1'b0);
        idle_a();

        // ---- reset state ----
        check("rst_halted",     64'(halted_b),     64'd0);
        check("rst_halt_valid", 64'(halt_valid_b), 64'd0);
        check("rst_cause",      64'(cause_b),      64'd0);
        check("rst_code",       64'(code_b),       64'd0);
        check("rst_pc",         pc_b,              64'd0);
        check("rst_retired",    ret_b,             64'd0);
        check("rst_cycles",     cyc_b,             64'd0);

        // ---- B: 5 addi then good ebreak, DRAIN_CYCLES=0 ----
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step_b(1'b1, c_ADDI, 64'h8000_0000 + 64'(4 * k), 64'd9, 1'b0);
        end
        step_b(1'b1, c_EBREAK, 64'h8000_0014, 64'd0, 1'b0);
        check("b_drain_not_halted", 64'(halted_b), 64'd0);
        step_b(1'b0, c_ADDI, 64'h0, 64'd0, 1'b0);
        check("b_halted",     64'(halted_b),     64'd1);
        check("b_halt_valid", 64'(halt_valid_b), 64'd1);
        check("b_cause",      64'(cause_b),      64'd1);
        check("b_code",       64'(code_b),       64'd0);
        check("b_pc",         pc_b,              64'h8000_0014);
        check("b_retired",    ret_b,             64'd6);
        check("b_cycles",     cyc_b,             64'd7);
        step_b(1'b1, c_EBREAK, 64'h9000, 64'd5, 1'b1);
        check("b_halt_valid_pulse", 64'(halt_valid_b), 64'd0);
        check("b_halted_sticky",    64'(halted_b),     64'd1);
        for (int k = 0; k < 19; k++) begin
            step_b(1'b1, c_EBREAK, 64'h9000, 64'd5, 1'b1);
        end
        check("b_cycles_frozen",  cyc_b,         64'd7);
        check("b_retired_frozen", ret_b,         64'd6);
        check("b_cause_frozen",   64'(cause_b),  64'd1);
        check("b_code_frozen",    64'(code_b),   64'd0);

        // ---- A: two-channel bad trap, ch1 behind ebreak not retired ----
        rst_a = 1'b0;
        step_a(2'b11, c_ADDI, c_ADDI, 64'h1000, 64'h1004, 64'd0, 1'b0);
        check("a_grp_retired", ret_a, 64'd2);
        step_a(2'b11, c_EBREAK, c_ADDI, 64'h1008, 64'h100C, 64'd3, 1'b0);
        check("a_bad_retired", ret_a,          64'd3);
        check("a_bad_cause",   64'(cause_a),   64'd2);
        check("a_bad_drain",   64'(halted_a),  64'd0);
        step_a(2'b11, c_EBREAK, c_EBREAK, 64'h5000, 64'h5004, 64'd0, 1'b1);
        check("a_drain2_not_halted", 64'(halted_a), 64'd0);
        check("a_drain_cause_kept",  64'(cause_a),  64'd2);
        idle_a();
        check("a_bad_halted",     64'(halted_a),     64'd1);
        check("a_bad_halt_valid", 64'(halt_valid_a), 64'd1);
        check("a_bad_code",       64'(code_a),       64'd3);
        check("a_bad_pc",         pc_a,              64'h1008);
        check("a_bad_retired2",   ret_a,             64'd3);
        check("a_bad_cycles",     cyc_a,             64'd4);

        // ---- A: ebreak beats halt_req, then reset mid-DRAIN ----
        reset_pulse_a();
        step_a(2'b11, c_ADDI, c_EBREAK, 64'h2000, 64'h2004, 64'd0, 1'b1);
        check("a_prio_cause",   64'(cause_a), 64'd1);
        check("a_prio_code",    64'(code_a),  64'd0);
        check("a_prio_pc",      pc_a,         64'h2004);
        check("a_prio_retired", ret_a,        64'd2);
        step_a(2'b00, c_ADDI, c_ADDI, 64'h0, 64'h0, 64'd0, 1'b1);
        check("a_prio_req_ignored", 64'(cause_a), 64'd1);
        reset_pulse_a();
        check("a_mid_rst_halted",  64'(halted_a), 64'd0);
        check("a_mid_rst_cause",   64'(cause_a),  64'd0);
        check("a_mid_rst_pc",      pc_a,          64'd0);
        check("a_mid_rst_code",    64'(code_a),   64'd0);
        check("a_mid_rst_retired", ret_a,         64'd0);
        check("a_mid_rst_cycles",  cyc_a,         64'd0);
        step_a(2'b01, c_EBREAK, c_ADDI, 64'h3000, 64'h3004, 64'd7, 1'b0);
        idle_a();
        check("a_post_rst_drain", 64'(halted_a), 64'd0);
        idle_a();
        check("a_post_rst_halted",  64'(halted_a), 64'd1);
        check("a_post_rst_cause",   64'(cause_a),  64'd2);
        check("a_post_rst_code",    64'(code_a),   64'd7);
        check("a_post_rst_retired", ret_a,         64'd1);
        check("a_post_rst_cycles",  cyc_a,         64'd3);

        // ---- A: external abort, last PC taken from the youngest channel ----
        reset_pulse_a();
        step_a(2'b01, c_ADDI, c_ADDI, 64'h4000, 64'h9999, 64'd0, 1'b0);
        step_a(2'b11, c_ADDI, c_ADDI, 64'h4010, 64'h4014, 64'd0, 1'b1);
        check("a_abort_cause",   64'(cause_a), 64'd4);
        check("a_abort_code",    64'(code_a),  64'hDEAD_0001);
        check("a_abort_pc",      pc_a,         64'h4014);
        check("a_abort_retired", ret_a,        64'd3);

        // ---- A: watchdog fires on the 8th idle cycle ----
        reset_pulse_a();
        step_a(2'b01, c_ADDI, c_ADDI, 64'h100, 64'h0, 64'd0, 1'b0);
        for (int k = 0; k < 7; k++) idle_a();
        check("a_wd_7_cause",  64'(cause_a),  64'd0);
        check("a_wd_7_halted", 64'(halted_a), 64'd0);
        idle_a();
        check("a_wd_cause", 64'(cause_a), 64'd3);
        check("a_wd_code",  64'(code_a),  64'hFFFF_FFFF);
        check("a_wd_pc",    pc_a,         64'h100);
        idle_a();
        idle_a();
        check("a_wd_halted",  64'(halted_a), 64'd1);
        check("a_wd_retired", ret_a,         64'd1);
        check("a_wd_cycles",  cyc_a,         64'd11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
